// File: rtl/program_counter.sv
// program_counter: 16-bit program counter with branch/return loads, stall and sync reset
module program_counter (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        w,
   input  logic        BRA,
   input  logic        STACK_POP,
   input  logic        FACT,
   input  logic [15:0] in,
   output logic [15:0] out
);
   logic [15:0] r_pc;
   logic [15:0] w_next;
   // next PC by priority: branch load, return load (in+2), stall hold, increment
   always_comb w_next = (w && BRA) ? in : (w && STACK_POP) ? in + 16'd2 : FACT ? r_pc : r_pc + 16'd1;
   // PC register; reset beats every other control
   always_ff @(posedge CLK) r_pc <= RESET ? 16'h0000 : w_next;
   assign out = r_pc;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: scoreboard bench for program_counter, directed then random
module tb_program_counter;
   logic        CLK = 1'b0;
   logic        RESET, w, BRA, STACK_POP, FACT;
   logic [15:0] in, out;
   logic [15:0] q_exp[$];
   string       q_tag[$];
   logic [15:0] m_pc;
   int          n_checks = 0;
   int          n_errors = 0;
   program_counter dut (
      .CLK(CLK), .RESET(RESET), .w(w), .BRA(BRA), .STACK_POP(STACK_POP),
      .FACT(FACT), .in(in), .out(out)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: out=%h expected=%h", tag, act, exp);
      end
   endtask
   task automatic step(input string tag, input logic r, input logic wv, input logic b,
                       input logic s, input logic f, input logic [15:0] d, input logic [15:0] exp);
      RESET = r; w = wv; BRA = b; STACK_POP = s; FACT = f; in = d;
      q_exp.push_back(exp);
      q_tag.push_back(tag);
      m_pc = exp;
      @(posedge CLK);
      #1;
      chk(q_tag.pop_front(), out, q_exp.pop_front());
   endtask
   initial begin
      step("reset",        1, 1, 1, 1, 1, 16'hBEEF, 16'h0000);
      step("count1",       0, 0, 0, 0, 0, 16'h0000, 16'h0001);
      step("count2",       0, 0, 0, 0, 0, 16'h0000, 16'h0002);
      step("bra_no_w",     0, 0, 1, 0, 0, 16'h7777, 16'h0003);
      step("bra_load",     0, 1, 1, 0, 0, 16'h6AB3, 16'h6AB3);
      step("w_only",       0, 1, 0, 0, 0, 16'h1111, 16'h6AB4);
      step("pop_load",     0, 1, 0, 1, 0, 16'h87AB, 16'h87AD);
      step("w_only2",      0, 1, 0, 0, 0, 16'h2222, 16'h87AE);
      step("pop_no_w",     0, 0, 0, 1, 0, 16'h3333, 16'h87AF);
      step("bra_over_pop", 0, 1, 1, 1, 0, 16'h1234, 16'h1234);
      step("stall1",       0, 0, 0, 0, 1, 16'h4444, 16'h1234);
      step("stall2",       0, 0, 0, 0, 1, 16'h4444, 16'h1234);
      step("stall3",       0, 0, 0, 0, 1, 16'h4444, 16'h1234);
      step("bra_over_fact",0, 1, 1, 0, 1, 16'h0100, 16'h0100);
      step("load_ffff",    0, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
      step("inc_wrap",     0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      step("pop_fffe",     0, 1, 0, 1, 0, 16'hFFFE, 16'h0000);
      step("pop_ffff",     0, 1, 0, 1, 0, 16'hFFFF, 16'h0001);
      step("bra_no_w_fact",0, 0, 1, 0, 1, 16'h5555, 16'h0001);
      step("pop_over_fact",0, 1, 0, 1, 1, 16'h0010, 16'h0012);
      step("stall_pre_rst",0, 1, 0, 0, 1, 16'h6666, 16'h0012);
      step("rst_in_stall", 1, 1, 1, 0, 1, 16'h5555, 16'h0000);
      step("post_reset",   0, 0, 0, 0, 0, 16'h0000, 16'h0001);
      for (int i = 0; i < 300; i++) begin
         logic       r, wv, b, s, f;
         logic [15:0] d, e;
         r  = ($urandom_range(0, 31) == 0);
         wv = $urandom_range(0, 1) == 1;
         b  = $urandom_range(0, 2) == 0;
         s  = $urandom_range(0, 2) == 0;
         f  = $urandom_range(0, 2) == 0;
         d  = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
         if (r) e = 16'h0000;
         else if (wv && b) e = d;
         else if (wv && s) e = d + 16'd2;
         else if (f) e = m_pc;
         else e = m_pc + 16'd1;
         step("random", r, wv, b, s, f, d, e);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
